// File: rtl/odometer_pkg.sv
// Shared types, glyph constants and BCD helper for the odometer display slice.
package odometer_pkg;

   typedef enum logic [1:0] {
      ST_NS = 2'b00,
      ST_SS = 2'b01,
      ST_MS = 2'b10,
      ST_PS = 2'b11
   } drive_state_e;

   typedef enum logic [1:0] {
      GSEL_BLANK = 2'd0,
      GSEL_DIGIT = 2'd1,
      GSEL_STATE = 2'd2
   } glyph_sel_e;

   localparam int NUM_DIGITS     = 8;
   localparam int MILEAGE_DIGITS = 6;

   localparam logic [7:0] GLYPH_0     = 8'hFC;
   localparam logic [7:0] GLYPH_1     = 8'h60;
   localparam logic [7:0] GLYPH_2     = 8'hDA;
   localparam logic [7:0] GLYPH_3     = 8'hF2;
   localparam logic [7:0] GLYPH_4     = 8'h66;
   localparam logic [7:0] GLYPH_5     = 8'hB6;
   localparam logic [7:0] GLYPH_6     = 8'hBE;
   localparam logic [7:0] GLYPH_7     = 8'hE0;
   localparam logic [7:0] GLYPH_8     = 8'hFE;
   localparam logic [7:0] GLYPH_9     = 8'hF6;
   localparam logic [7:0] GLYPH_N     = 8'h2A;
   localparam logic [7:0] GLYPH_S     = 8'hB6;
   localparam logic [7:0] GLYPH_D     = 8'h7A;
   localparam logic [7:0] GLYPH_P     = 8'hCE;
   localparam logic [7:0] GLYPH_BLANK = 8'h00;

   // Ripple-carry BCD increment; MSB of the result is the carry out of the top digit.
   function automatic logic [4*MILEAGE_DIGITS:0] bcd_increment(
      input logic [4*MILEAGE_DIGITS-1:0] value
   );
      logic [4*MILEAGE_DIGITS-1:0] result;
      logic                        carry;
      result = value;
      carry  = 1'b1;
      for (int i = 0; i < MILEAGE_DIGITS; i++) begin
         if (carry) begin
            if (value[i*4 +: 4] == 4'd9) begin
               result[i*4 +: 4] = 4'd0;
               carry            = 1'b1;
            end else begin
               result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
               carry            = 1'b0;
            end
         end else begin
            result[i*4 +: 4] = value[i*4 +: 4];
         end
      end
      return {carry, result};
   endfunction

endpackage

// File: rtl/odometer_display_seg7_glyph.sv
// Combinational decoder: 4-bit value plus glyph class to active-high {a..g,dp} segments.
module seg7_glyph
   import odometer_pkg::*;
(
   input  logic [3:0]  i_value,
   input  glyph_sel_e  i_sel,
   output logic [7:0]  o_seg
);

   always_comb begin
      o_seg = GLYPH_BLANK;
      case (i_sel)
         GSEL_DIGIT: begin
            case (i_value)
               4'd0:    o_seg = GLYPH_0;
               4'd1:    o_seg = GLYPH_1;
               4'd2:    o_seg = GLYPH_2;
               4'd3:    o_seg = GLYPH_3;
               4'd4:    o_seg = GLYPH_4;
               4'd5:    o_seg = GLYPH_5;
               4'd6:    o_seg = GLYPH_6;
               4'd7:    o_seg = GLYPH_7;
               4'd8:    o_seg = GLYPH_8;
               4'd9:    o_seg = GLYPH_9;
               default: o_seg = GLYPH_BLANK;
            endcase
         end
         GSEL_STATE: begin
            case (drive_state_e'(i_value[1:0]))
               ST_NS:   o_seg = GLYPH_N;
               ST_SS:   o_seg = GLYPH_S;
               ST_MS:   o_seg = GLYPH_D;
               ST_PS:   o_seg = GLYPH_P;
               default: o_seg = GLYPH_BLANK;
            endcase
         end
         default: o_seg = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/odometer_display.sv
// Motion-driven 6-digit BCD odometer with an 8-digit multiplexed seven-segment scan:
// driving-state glyph in the leftmost slot, blank slot, then mileage digits.
module odometer_display
   import odometer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned SCAN_DIV = 100_000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        move_forward_signal,
   input  logic        move_backward_signal,
   input  logic [1:0]  state,
   input  logic        clear,
   output logic [23:0] mileage_bcd,
   output logic        mileage_wrap,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_out
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [23:0]   r_mileage_bcd;
   logic          r_wrap;
   logic [SW-1:0] r_scan;
   logic [2:0]    r_index;
   logic [7:0]    r_seg_en;
   logic [7:0]    r_seg_out;

   logic          w_moving;
   logic          w_tick;
   logic [24:0]   w_inc;
   logic [3:0]    w_nibble;
   glyph_sel_e    w_sel;
   logic [7:0]    w_seg;

   assign w_moving = move_forward_signal | move_backward_signal;
   assign w_tick   = w_moving && (r_presc == PRESC_LAST);
   assign w_inc    = bcd_increment(r_mileage_bcd);

   // Odometer: prescale motion cycles, step the BCD count, flag 999999 -> 000000.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc       <= '0;
         r_mileage_bcd <= 24'h000000;
         r_wrap        <= 1'b0;
      end else if (clear) begin
         r_presc       <= '0;
         r_mileage_bcd <= 24'h000000;
         r_wrap        <= 1'b0;
      end else if (w_tick) begin
         r_presc       <= '0;
         r_mileage_bcd <= w_inc[23:0];
         r_wrap        <= w_inc[24];
      end else if (w_moving) begin
         r_presc       <= r_presc + {{(PW-1){1'b0}}, 1'b1};
         r_wrap        <= 1'b0;
      end else begin
         r_wrap        <= 1'b0;
      end
   end

   // Digit slot timer and index, free-running regardless of motion or clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan  <= '0;
         r_index <= 3'd0;
      end else if (r_scan == SCAN_LAST) begin
         r_scan  <= '0;
         r_index <= r_index + 3'd1;
      end else begin
         r_scan  <= r_scan + {{(SW-1){1'b0}}, 1'b1};
      end
   end

   // Slots 0..5 show mileage digits, 6 is blank, 7 shows the driving-state glyph.
   always_comb begin
      w_nibble = 4'h0;
      w_sel    = GSEL_BLANK;
      if (r_index < 3'd6) begin
         w_nibble = r_mileage_bcd[{r_index, 2'b00} +: 4];
         w_sel    = GSEL_DIGIT;
      end else if (r_index == 3'd7) begin
         w_nibble = {2'b00, state};
         w_sel    = GSEL_STATE;
      end else begin
         w_nibble = 4'h0;
         w_sel    = GSEL_BLANK;
      end
   end

   seg7_glyph u_glyph (
      .i_value (w_nibble),
      .i_sel   (w_sel),
      .o_seg   (w_seg)
   );

   // Display drive registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_seg_en  <= 8'h00;
         r_seg_out <= 8'h00;
      end else begin
         r_seg_en  <= 8'h01 << r_index;
         r_seg_out <= w_seg;
      end
   end

   assign mileage_bcd  = r_mileage_bcd;
   assign mileage_wrap = r_wrap;
   assign seg_en       = r_seg_en;
   assign seg_out      = r_seg_out;

endmodule

// File: tb/tb_odometer_display.sv
// Directed bench with a decimal reference model feeding an expected-result queue.
module tb_odometer_display;

   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;

   typedef struct {
      logic [23:0] mil;
      logic        wrap;
      logic [7:0]  en;
      logic [7:0]  seg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fwd = 1'b0;
   logic        bwd = 1'b0;
   logic [1:0]  st = 2'b00;
   logic        clr = 1'b0;
   logic [23:0] mileage_bcd;
   logic        mileage_wrap;
   logic [7:0]  seg_en;
   logic [7:0]  seg_out;

   int checks = 0;
   int errors = 0;
   int m_presc = 0, m_mil = 0, m_scan = 0, m_idx = 0;
   exp_t sb[$];

   odometer_display #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .move_forward_signal  (fwd),
      .move_backward_signal (bwd),
      .state                (st),
      .clear                (clr),
      .mileage_bcd          (mileage_bcd),
      .mileage_wrap         (mileage_wrap),
      .seg_en               (seg_en),
      .seg_out              (seg_out)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int          t;
      t = v;
      r = 24'h0;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] digit_seg(input int d);
      case (d)
         0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
         4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
         8: return 8'hFE;  9: return 8'hF6;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] state_seg(input logic [1:0] s);
      case (s)
         2'b00: return 8'h2A;
         2'b01: return 8'hB6;
         2'b10: return 8'h7A;
         default: return 8'hCE;
      endcase
   endfunction

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One clock: advance the model, queue its prediction, clock the DUT, compare.
   task automatic step(input logic f, input logic b, input logic c, input logic rn);
      exp_t e;
      int   p;
      e.wrap = 1'b0;
      if (!rn) begin
         m_presc = 0; m_mil = 0; m_scan = 0; m_idx = 0;
         e.en = 8'h00; e.seg = 8'h00;
      end else begin
         e.en = 8'h01 << m_idx;
         if (m_idx < 6) begin
            p = 1;
            for (int i = 0; i < m_idx; i++) p = p * 10;
            e.seg = digit_seg((m_mil / p) % 10);
         end else if (m_idx == 6) begin
            e.seg = 8'h00;
         end else begin
            e.seg = state_seg(st);
         end
         if (m_scan == SCAN_DIV - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 8;
         end else begin
            m_scan++;
         end
         if (c) begin
            m_presc = 0; m_mil = 0;
         end else if (f || b) begin
            if (m_presc == TICK_DIV - 1) begin
               m_presc = 0;
               if (m_mil == 999999) begin
                  m_mil  = 0;
                  e.wrap = 1'b1;
               end else begin
                  m_mil++;
               end
            end else begin
               m_presc++;
            end
         end
      end
      e.mil = to_bcd(m_mil);
      sb.push_back(e);
      fwd = f; bwd = b; clr = c; rst_n = rn;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("mileage_bcd", mileage_bcd, e.mil);
      check("mileage_wrap", {23'd0, mileage_wrap}, {23'd0, e.wrap});
      check("seg_en", {16'd0, seg_en}, {16'd0, e.en});
      check("seg_out", {16'd0, seg_out}, {16'd0, e.seg});
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      // Basic counting and partial-progress retention.
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("mil_after_12", mileage_bcd, 24'h000003);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("mil_held_presc", mileage_bcd, 24'h000004);
      // Digit carries 9->10 and 999->1000.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      check("mil_9", mileage_bcd, 24'h000009);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("mil_10", mileage_bcd, 24'h000010);
      for (int i = 0; i < 989 * 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("mil_999", mileage_bcd, 24'h000999);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("mil_1000", mileage_bcd, 24'h001000);
      // Full wrap from 999999.
      force dut.r_mileage_bcd = 24'h999999;
      #1;
      release dut.r_mileage_bcd;
      m_mil = 999999;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("wrap_pulse", {23'd0, mileage_wrap}, 24'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("wrap_one_cycle", {23'd0, mileage_wrap}, 24'd0);
      // Clear beats a coincident tick.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("clear_on_tick", mileage_bcd, 24'h000000);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("after_clear", mileage_bcd, 24'h000001);
      // Display scan at 000042 in the moving state, with state changes mid-scan.
      for (int i = 0; i < 41 * 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      st = 2'b10;
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int s = 0; s < 4; s++) begin
         st = 2'(s);
         for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      // Both direction signals count as motion.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      check("both_dirs", mileage_bcd, 24'h000044);
      // Mid-count reset, then display restarts from slot 0.
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("seg_en_restart", {16'd0, seg_en}, 24'h000001);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
